// File: rtl/id_operand_issue_if.sv
// rtl/id_operand_issue_if.sv - ID->EX issue bus (valid/allowin handshake plus issued payload)
//
// Purpose: carries one issued instruction and its resolved operands from ID to EX.
// Signals:
//   ex_valid   producer -> consumer  issued instruction valid
//   ex_allowin consumer -> producer  EX can accept this cycle
//   ex_pc      producer -> consumer  issued pc
//   ex_inst    producer -> consumer  issued instruction
//   ex_src1    producer -> consumer  resolved first operand
//   ex_src2    producer -> consumer  resolved second operand
// Modports: master = ID (producer), slave = EX (consumer).
interface id_operand_issue_if #(
  parameter int XLEN = 32
);
  logic            ex_valid;
  logic            ex_allowin;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_inst;
  logic [XLEN-1:0] ex_src1;
  logic [XLEN-1:0] ex_src2;

  modport master (
    output ex_valid, ex_pc, ex_inst, ex_src1, ex_src2,
    input  ex_allowin
  );

  modport slave (
    input  ex_valid, ex_pc, ex_inst, ex_src1, ex_src2,
    output ex_allowin
  );
endinterface

// File: rtl/id_operand_issue.sv
// rtl/id_operand_issue.sv - ID-stage operand issue with EX/MEM/WB bypass and load-use stall
//
// Purpose: holds the IF->ID instruction register, reads the register file, resolves
// each operand through the EX > MEM > WB > RF bypass chain, stalls on a load-use
// hazard and registers the result onto the ID->EX bus.
// Optional feature macro: ID_STALL_CNT_EN (load-use stall cycle counter on stall_cnt;
// when undefined stall_cnt is constant 0 and no counter flops exist).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   if_valid/if_pc/if_inst   instruction offered by IF; id_allowin back to IF
//   flush                    redirect from EX, kills the ID instruction
//   id_pc/id_inst            held instruction towards the decoder
//   dec_use1/use2/src2_rd    decoder source usage for the held instruction
//   rf_raddr1/2, rf_rdata1/2 register file read port (combinational data)
//   ex_/mem_/wb_fwd_*        forwarding ports (valid, addr, data)
//   ex_ld_pending/ld_addr    load in EX and its destination
//   ex_bus                   ID->EX bus (master side)
//   stall_cnt                load-use stall cycle count
module id_operand_issue #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  input  logic [XLEN-1:0] if_inst,
  output logic            id_allowin,
  input  logic            flush,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_inst,
  input  logic            dec_use1,
  input  logic            dec_use2,
  input  logic            dec_src2_rd,
  output logic [RA_W-1:0] rf_raddr1,
  output logic [RA_W-1:0] rf_raddr2,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  input  logic            ex_fwd_valid,
  input  logic [RA_W-1:0] ex_fwd_addr,
  input  logic [XLEN-1:0] ex_fwd_data,
  input  logic            ex_ld_pending,
  input  logic [RA_W-1:0] ex_ld_addr,
  input  logic            mem_fwd_valid,
  input  logic [RA_W-1:0] mem_fwd_addr,
  input  logic [XLEN-1:0] mem_fwd_data,
  input  logic            wb_fwd_valid,
  input  logic [RA_W-1:0] wb_fwd_addr,
  input  logic [XLEN-1:0] wb_fwd_data,
  id_operand_issue_if.master ex_bus,
  output logic [31:0]     stall_cnt
);

  logic            id_valid_q, id_valid_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic [XLEN-1:0] id_inst_q, id_inst_d;
  logic            ex_valid_q, ex_valid_d;
  logic [XLEN-1:0] ex_pc_q, ex_pc_d;
  logic [XLEN-1:0] ex_inst_q, ex_inst_d;
  logic [XLEN-1:0] ex_src1_q, ex_src1_d;
  logic [XLEN-1:0] ex_src2_q, ex_src2_d;

  logic [RA_W-1:0] rj_addr, src2_addr;
  logic            ex_allowin;
  logic            stall, id_ready_go;
  logic [XLEN-1:0] src1_val, src2_val;

  assign ex_allowin = ex_bus.ex_allowin;

  // LoongArch-style fields: rd[4:0], rj[9:5], rk[14:10].
  assign rj_addr   = id_inst_q[9:5];
  assign src2_addr = dec_src2_rd ? id_inst_q[4:0] : id_inst_q[14:10];
  assign rf_raddr1 = rj_addr;
  assign rf_raddr2 = src2_addr;

  // A load in EX cannot be forwarded yet; its consumer must wait one cycle.
  assign stall = id_valid_q & ex_ld_pending & (ex_ld_addr != '0) &
                 ((dec_use1 & (ex_ld_addr == rj_addr)) |
                  (dec_use2 & (ex_ld_addr == src2_addr)));
  assign id_ready_go = ~stall;
  assign id_allowin  = ~id_valid_q | (id_ready_go & ex_allowin);

  // Youngest producer wins; r0 is hard-wired to zero regardless of forwards.
  function automatic logic [XLEN-1:0] bypass(input logic [RA_W-1:0] a,
                                             input logic [XLEN-1:0] rf_val);
    if (a == '0)                              return '0;
    else if (ex_fwd_valid  && ex_fwd_addr  == a) return ex_fwd_data;
    else if (mem_fwd_valid && mem_fwd_addr == a) return mem_fwd_data;
    else if (wb_fwd_valid  && wb_fwd_addr  == a) return wb_fwd_data;
    else                                      return rf_val;
  endfunction

  assign src1_val = bypass(rj_addr, rf_rdata1);
  assign src2_val = bypass(src2_addr, rf_rdata2);

  always_comb begin
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    ex_valid_d = ex_valid_q;
    ex_pc_d    = ex_pc_q;
    ex_inst_d  = ex_inst_q;
    ex_src1_d  = ex_src1_q;
    ex_src2_d  = ex_src2_q;

    if (flush) begin
      id_valid_d = 1'b0;
    end else if (id_allowin) begin
      id_valid_d = if_valid;
      if (if_valid) begin
        id_pc_d   = if_pc;
        id_inst_d = if_inst;
      end
    end

    // When EX is blocked the whole bus holds, so a stall creates no bubble then.
    if (ex_allowin) begin
      ex_valid_d = id_valid_q & id_ready_go & ~flush;
      ex_pc_d    = id_pc_q;
      ex_inst_d  = id_inst_q;
      ex_src1_d  = src1_val;
      ex_src2_d  = src2_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_inst_q  <= '0;
      ex_valid_q <= 1'b0;
      ex_pc_q    <= '0;
      ex_inst_q  <= '0;
      ex_src1_q  <= '0;
      ex_src2_q  <= '0;
    end else begin
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      ex_valid_q <= ex_valid_d;
      ex_pc_q    <= ex_pc_d;
      ex_inst_q  <= ex_inst_d;
      ex_src1_q  <= ex_src1_d;
      ex_src2_q  <= ex_src2_d;
    end
  end

  assign id_pc           = id_pc_q;
  assign id_inst         = id_inst_q;
  assign ex_bus.ex_valid = ex_valid_q;
  assign ex_bus.ex_pc    = ex_pc_q;
  assign ex_bus.ex_inst  = ex_inst_q;
  assign ex_bus.ex_src1  = ex_src1_q;
  assign ex_bus.ex_src2  = ex_src2_q;

`ifdef ID_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Counts only cycles where the stall actually costs an issue slot.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && ex_allowin && !flush) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_id_operand_issue.sv
// tb/tb_id_operand_issue.sv - self-checking bench for id_operand_issue
module tb_id_operand_issue;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_valid = 1'b0;
  logic [31:0] if_pc = '0, if_inst = '0;
  logic        id_allowin;
  logic        flush = 1'b0;
  logic [31:0] id_pc, id_inst;
  logic        dec_use1 = 1'b0, dec_use2 = 1'b0, dec_src2_rd = 1'b0;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        ex_ld_pending = 1'b0;
  logic [4:0]  ex_ld_addr = '0;
  logic [31:0] stall_cnt;

  // Forward sources indexed by priority: 0 = EX, 1 = MEM, 2 = WB.
  logic        fv [3];
  logic [4:0]  fa [3];
  logic [31:0] fd [3];
  logic [31:0] rf_mem [32];

  assign rf_rdata1 = rf_mem[rf_raddr1];
  assign rf_rdata2 = rf_mem[rf_raddr2];

  id_operand_issue_if #(.XLEN(32)) ex_bus ();

  id_operand_issue #(.XLEN(32), .RA_W(5)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .id_allowin(id_allowin),
    .flush(flush), .id_pc(id_pc), .id_inst(id_inst),
    .dec_use1(dec_use1), .dec_use2(dec_use2), .dec_src2_rd(dec_src2_rd),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .ex_fwd_valid(fv[0]), .ex_fwd_addr(fa[0]), .ex_fwd_data(fd[0]),
    .ex_ld_pending(ex_ld_pending), .ex_ld_addr(ex_ld_addr),
    .mem_fwd_valid(fv[1]), .mem_fwd_addr(fa[1]), .mem_fwd_data(fd[1]),
    .wb_fwd_valid(fv[2]), .wb_fwd_addr(fa[2]), .wb_fwd_data(fd[2]),
    .ex_bus(ex_bus.master),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_inst(input logic [4:0] rd, input logic [4:0] rj,
                                          input logic [4:0] rk);
    return {17'h0, rk, rj, rd};
  endfunction

  task automatic clear_fwd();
    for (int s = 0; s < 3; s++) begin
      fv[s] = 1'b0; fa[s] = '0; fd[s] = '0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; if_valid = 1'b0; flush = 1'b0; ex_ld_pending = 1'b0;
    ex_bus.ex_allowin = 1'b1; clear_fwd();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- reference model (transaction level) ----------------
  typedef struct {
    logic        v;
    logic [31:0] pc, inst, s1, s2;
  } slot_t;

  slot_t m_id, m_ex;
  logic [31:0] m_cnt;
  logic        m_take;

  function automatic logic [31:0] m_value(input logic [4:0] a);
    if (a == 0) return 32'h0;
    for (int s = 0; s < 3; s++)
      if (fv[s] && fa[s] == a) return fd[s];
    return rf_mem[a];
  endfunction

  // Compute the effect of the coming edge from the current inputs.
  task automatic m_step();
    logic [4:0] a1, a2;
    logic       hz;
    slot_t      n_id, n_ex;
    a1 = m_id.inst[9:5];
    a2 = dec_src2_rd ? m_id.inst[4:0] : m_id.inst[14:10];
    hz = m_id.v && ex_ld_pending && ex_ld_addr != 0 &&
         ((dec_use1 && ex_ld_addr == a1) || (dec_use2 && ex_ld_addr == a2));
    m_take = !m_id.v || (!hz && ex_bus.ex_allowin);
    n_id = m_id;
    n_ex = m_ex;
    if (ex_bus.ex_allowin) begin
      n_ex.v = m_id.v && !hz && !flush;
      n_ex.pc = m_id.pc; n_ex.inst = m_id.inst;
      n_ex.s1 = m_value(a1); n_ex.s2 = m_value(a2);
    end
    if (flush) n_id.v = 1'b0;
    else if (m_take) begin
      n_id.v = if_valid;
      if (if_valid) begin n_id.pc = if_pc; n_id.inst = if_inst; end
    end
`ifdef ID_STALL_CNT_EN
    if (hz && ex_bus.ex_allowin && !flush) m_cnt = m_cnt + 1;
`endif
    m_id = n_id;
    m_ex = n_ex;
  endtask

  // ---------------- bypass vector table ----------------
  typedef struct {
    logic [4:0]  a1, a2;
    logic        v0, v1, v2;
    logic [4:0]  a_0, a_1, a_2;
    logic [31:0] d_0, d_1, d_2;
    logic [31:0] rf1, rf2;
    logic [31:0] e1, e2;
    string       name;
  } vec_t;

  vec_t vt [8];

  initial begin
    logic [31:0] base;
    logic [31:0] cnt0;
    ex_bus.ex_allowin = 1'b1;
    clear_fwd();
    for (int r = 0; r < 32; r++) rf_mem[r] = 32'h1000_0000 + r;

    vt[0] = '{5, 0, 1,1,1, 5,5,5, 32'h11,32'h22,32'h33, 32'h44,32'hDEAD, 32'h11,32'h0,  "byp_ex"};
    vt[1] = '{5, 0, 0,1,1, 5,5,5, 32'h11,32'h22,32'h33, 32'h44,32'hDEAD, 32'h22,32'h0,  "byp_mem"};
    vt[2] = '{5, 0, 0,0,1, 5,5,5, 32'h11,32'h22,32'h33, 32'h44,32'hDEAD, 32'h33,32'h0,  "byp_wb"};
    vt[3] = '{5, 0, 0,0,0, 5,5,5, 32'h11,32'h22,32'h33, 32'h44,32'hDEAD, 32'h44,32'h0,  "byp_rf"};
    vt[4] = '{0, 0, 1,1,1, 0,0,0, 32'hDEAD,32'hDEAD,32'hDEAD, 32'hDEAD,32'hDEAD, 32'h0,32'h0, "byp_r0"};
    vt[5] = '{3, 9, 1,1,1, 9,3,9, 32'hA,32'hB,32'hC, 32'h300,32'h900, 32'hB,32'hA, "byp_mix"};
    vt[6] = '{6, 6, 0,0,1, 6,6,6, 32'hE,32'hF,32'h5, 32'h600,32'h600, 32'h5,32'h5, "byp_same"};
    vt[7] = '{12, 20, 1,1,1, 13,21,2, 32'h1,32'h2,32'h3, 32'hC0,32'h140, 32'hC0,32'h140, "byp_miss"};

    // 1. reset
    do_reset();
    #1;
    check("rst_ex_valid", {31'h0, ex_bus.ex_valid}, 32'h0);
    check("rst_id_allowin", {31'h0, id_allowin}, 32'h1);
    check("rst_stall_cnt", stall_cnt, 32'h0);
    check("rst_ex_pc", ex_bus.ex_pc, 32'h0);
    check("rst_id_inst", id_inst, 32'h0);

    // 2. no-hazard stream, one-cycle issue latency
    base = 32'h1C00_0000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        check("stream_ex_valid", {31'h0, ex_bus.ex_valid}, 32'h1);
        check("stream_ex_pc", ex_bus.ex_pc, base + 4 * (i - 2));
        check("stream_id_pc", id_pc, base + 4 * (i - 1));
      end
      if_valid = 1'b1; if_pc = base + 4 * i; if_inst = mk_inst(1, 2, 3);
      dec_use1 = 1'b1; dec_use2 = 1'b1; dec_src2_rd = 1'b0;
    end
    @(negedge clk); if_valid = 1'b0;

    // 3/5. table-driven bypass priority and r0 handling
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      clear_fwd();
      if_valid = 1'b1; if_pc = 32'h2000 + 4 * k; if_inst = mk_inst(0, vt[k].a1, vt[k].a2);
      dec_use1 = 1'b1; dec_use2 = 1'b1; dec_src2_rd = 1'b0;
      @(negedge clk);
      if_valid = 1'b0;
      fv[0] = vt[k].v0; fv[1] = vt[k].v1; fv[2] = vt[k].v2;
      fa[0] = vt[k].a_0; fa[1] = vt[k].a_1; fa[2] = vt[k].a_2;
      fd[0] = vt[k].d_0; fd[1] = vt[k].d_1; fd[2] = vt[k].d_2;
      rf_mem[vt[k].a1] = vt[k].rf1;
      rf_mem[vt[k].a2] = vt[k].rf2;
      @(negedge clk);
      check({vt[k].name, "_src1"}, ex_bus.ex_src1, vt[k].e1);
      check({vt[k].name, "_src2"}, ex_bus.ex_src2, vt[k].e2);
      check({vt[k].name, "_valid"}, {31'h0, ex_bus.ex_valid}, 32'h1);
    end
    clear_fwd();

    // 4. load-use stall on rk, then issue with MEM-forwarded value
    do_reset();
    if_valid = 1'b1; if_pc = 32'h3000; if_inst = mk_inst(0, 0, 7);
    dec_use1 = 1'b1; dec_use2 = 1'b1; dec_src2_rd = 1'b0;
    @(negedge clk);
    if_valid = 1'b1; if_pc = 32'h3004; if_inst = mk_inst(0, 0, 0);
    ex_ld_pending = 1'b1; ex_ld_addr = 5'd7;
    #1 check("lu_id_allowin_stall", {31'h0, id_allowin}, 32'h0);
    @(negedge clk);
    check("lu_bubble", {31'h0, ex_bus.ex_valid}, 32'h0);
    check("lu_id_pc_held", id_pc, 32'h3000);
    ex_ld_pending = 1'b0; if_valid = 1'b0;
    fv[1] = 1'b1; fa[1] = 5'd7; fd[1] = 32'h77; rf_mem[7] = 32'h99;
    #1 check("lu_id_allowin_go", {31'h0, id_allowin}, 32'h1);
    @(negedge clk);
    check("lu_issue_valid", {31'h0, ex_bus.ex_valid}, 32'h1);
    check("lu_issue_pc", ex_bus.ex_pc, 32'h3000);
    check("lu_issue_src2", ex_bus.ex_src2, 32'h77);
`ifdef ID_STALL_CNT_EN
    check("lu_stall_cnt", stall_cnt, 32'h1);
`else
    check("lu_stall_cnt", stall_cnt, 32'h0);
`endif
    clear_fwd();

    // 6. flush during a load-use stall kills the instruction
    do_reset();
    if_valid = 1'b1; if_pc = 32'h4000; if_inst = mk_inst(0, 0, 7);
    dec_use1 = 1'b0; dec_use2 = 1'b1; dec_src2_rd = 1'b0;
    @(negedge clk);
    if_valid = 1'b0; ex_ld_pending = 1'b1; ex_ld_addr = 5'd7;
    @(negedge clk);
    check("fl_bubble", {31'h0, ex_bus.ex_valid}, 32'h0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; ex_ld_pending = 1'b0;
    #1 check("fl_id_empty", {31'h0, id_allowin}, 32'h1);
    check("fl_ex_valid", {31'h0, ex_bus.ex_valid}, 32'h0);
    @(negedge clk);
    check("fl_no_issue", {31'h0, ex_bus.ex_valid}, 32'h0);
`ifdef ID_STALL_CNT_EN
    check("fl_stall_cnt", stall_cnt, 32'h1);
`else
    check("fl_stall_cnt", stall_cnt, 32'h0);
`endif

    // stall + ex_allowin=0 holds without a bubble; then reset mid-stall
    if_valid = 1'b1; if_pc = 32'h5000; if_inst = mk_inst(0, 7, 0);
    dec_use1 = 1'b1; dec_use2 = 1'b0;
    @(negedge clk);
    if_valid = 1'b0; ex_ld_pending = 1'b1; ex_ld_addr = 5'd7;
    ex_bus.ex_allowin = 1'b0;
    @(negedge clk);
    check("hold_ex_pc", ex_bus.ex_pc, 32'h4000);
    ex_bus.ex_allowin = 1'b1;
    cnt0 = stall_cnt;
    @(negedge clk);
`ifdef ID_STALL_CNT_EN
    check("hold_cnt_step", stall_cnt - cnt0, 32'h1);
`else
    check("hold_cnt_step", stall_cnt - cnt0, 32'h0);
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; ex_ld_pending = 1'b0;
    #1;
    check("rst_mid_cnt", stall_cnt, 32'h0);
    check("rst_mid_valid", {31'h0, ex_bus.ex_valid}, 32'h0);
    check("rst_mid_allowin", {31'h0, id_allowin}, 32'h1);
    check("rst_mid_id_pc", id_pc, 32'h0);

    // randomized run against the transaction-level model
    do_reset();
    m_id = '{1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
    m_ex = '{1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
    m_cnt = '0;
    for (int c = 0; c < 400; c++) begin
      check("rnd_ex_valid", {31'h0, ex_bus.ex_valid}, {31'h0, m_ex.v});
      check("rnd_ex_pc", ex_bus.ex_pc, m_ex.pc);
      check("rnd_ex_inst", ex_bus.ex_inst, m_ex.inst);
      check("rnd_ex_src1", ex_bus.ex_src1, m_ex.s1);
      check("rnd_ex_src2", ex_bus.ex_src2, m_ex.s2);
      check("rnd_id_pc", id_pc, m_id.pc);
      check("rnd_stall_cnt", stall_cnt, m_cnt);
      if_valid = ($urandom_range(0, 3) != 0);
      if_pc = $urandom;
      if_inst = $urandom;
      if_inst[4:0] = 5'($urandom_range(0, 7));
      if_inst[9:5] = 5'($urandom_range(0, 7));
      if_inst[14:10] = 5'($urandom_range(0, 7));
      dec_use1 = 1'($urandom); dec_use2 = 1'($urandom); dec_src2_rd = 1'($urandom);
      for (int s = 0; s < 3; s++) begin
        fv[s] = 1'($urandom); fa[s] = 5'($urandom_range(0, 7)); fd[s] = $urandom;
      end
      rf_mem[$urandom_range(1, 7)] = $urandom;
      ex_ld_pending = ($urandom_range(0, 2) == 0);
      ex_ld_addr = 5'($urandom_range(0, 7));
      flush = ($urandom_range(0, 9) == 0);
      ex_bus.ex_allowin = ($urandom_range(0, 3) != 0);
      #1;
      m_step();
      check("rnd_id_allowin", {31'h0, id_allowin}, {31'h0, m_take});
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
